// File: rtl/bsg_clk_gen_pearl_pkg.sv
// Shared types and constants for the clk-gen pearl tag path: packet header
// layout, local tag node offsets and the tag sender state encoding.
package bsg_clk_gen_pearl_pkg;

  function automatic int bsg_safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  localparam int bsg_tag_els_gp      = 16;
  localparam int bsg_tag_id_width_gp = bsg_safe_clog2(bsg_tag_els_gp);
  localparam int bsg_tag_lg_width_gp = 4;

  // Packed LSB-first: node_id occupies the low bits because it goes on the wire first.
  typedef struct packed {
    logic [bsg_tag_lg_width_gp-1:0] len;
    logic                           data_not_reset;
    logic [bsg_tag_id_width_gp-1:0] node_id;
  } bsg_tag_pkt_hdr_s;

  localparam int osc_node_offset_gp           = 0;
  localparam int osc_trigger_node_offset_gp   = 1;
  localparam int ds_node_offset_gp            = 2;
  localparam int sel_node_offset_gp           = 3;
  localparam int async_reset_node_offset_gp   = 4;
  localparam int monitor_reset_node_offset_gp = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    GAP     = 2'd3
  } tag_sender_state_e;

endpackage

// File: rtl/bsg_clk_gen_pearl_tag_shifter.sv
// Loadable LSB-first parallel-in/serial-out register with a remaining-bit
// down-counter; the owning FSM decides when to load, shift and count.
module bsg_clk_gen_pearl_tag_shifter #(
  parameter int width_p = 8,
  parameter int cnt_w_p = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               shift,
  input  logic               count_load,
  input  logic               count_dec,
  input  logic [width_p-1:0] load_data,
  input  logic [cnt_w_p-1:0] count_init,
  output logic               bit_out,
  output logic [cnt_w_p-1:0] count
);

  logic [width_p-1:0] sh;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh    <= '0;
      count <= '0;
    end else begin
      if (load)
        sh <= load_data;
      else if (shift)
        sh <= sh >> 1;

      if (count_load)
        count <= count_init;
      else if (count_dec)
        count <= count - cnt_w_p'(1);
    end
  end

  assign bit_out = sh[0];

endmodule

// File: rtl/bsg_clk_gen_pearl_tag_sender.sv
// bsg_tag packet serializer for the clk-gen pearl: one packet per valid/ready
// handshake, one bit per clk_i. Define BSG_CLK_GEN_PEARL_TAG_SENDER_GAP_EN for idle gap bits.
//  state   | meaning
//  IDLE    | line held at 0, ready for a packet
//  HDR     | shifting node_id, data_not_reset, len
//  PAYLOAD | shifting the len payload bits
//  GAP     | gap_p trailing zero bits before the next packet
module bsg_clk_gen_pearl_tag_sender
  import bsg_clk_gen_pearl_pkg::*;
#(
  parameter  int tag_els_p      = 16,
  parameter  int tag_lg_width_p = 4,
  parameter  int gap_p          = 4,
  localparam int id_w           = bsg_safe_clog2(tag_els_p),
  localparam int len_max        = (1 << tag_lg_width_p) - 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  output logic                      ready_and_o,
  input  logic [id_w-1:0]           node_id_i,
  input  logic                      data_not_reset_i,
  input  logic [tag_lg_width_p-1:0] len_i,
  input  logic [len_max-1:0]        payload_i,
  output logic                      tag_data_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int hdr_w = id_w + 1 + tag_lg_width_p;
  localparam int sh_w  = hdr_w + len_max;
  localparam int cnt_w = $clog2(len_max + id_w + tag_lg_width_p + 3);

  typedef struct packed {
    logic [tag_lg_width_p-1:0] len;
    logic                      data_not_reset;
    logic [id_w-1:0]           node_id;
  } hdr_s;

  if (gap_p < 0) begin : g_bad_gap
    $error("gap_p must be non-negative");
  end

`ifdef BSG_CLK_GEN_PEARL_TAG_SENDER_GAP_EN
  localparam bit gap_en = (gap_p > 0);
  if (gap_p >= (1 << cnt_w)) begin : g_gap_too_big
    $error("gap_p does not fit the bit counter");
  end
`else
  localparam bit gap_en = 1'b0;
`endif

  tag_sender_state_e         state;
  hdr_s                      hdr;
  logic [len_max-1:0]        payload_masked;
  logic [tag_lg_width_p-1:0] len_q;
  logic [cnt_w-1:0]          count;
  logic [cnt_w-1:0]          count_init;
  logic                      accept;
  logic                      sending;
  logic                      send_last;
  logic                      count_load;
  logic                      shift_bit;
  logic                      last;

  assign ready_and_o = (state == IDLE) & ~reset_i;
  assign accept      = v_i & ready_and_o;
  assign sending     = (state == HDR) | (state == PAYLOAD);
  assign send_last   = sending & (count == cnt_w'(1));

  assign hdr.len            = len_i;
  assign hdr.data_not_reset = data_not_reset_i;
  assign hdr.node_id        = node_id_i;

  // Bits above len_i never reach the wire; clearing them keeps the register contents clean.
  assign payload_masked = payload_i & ({len_max{1'b1}} >> (len_max - int'(len_i)));

  assign count_load = accept | (gap_en & send_last);
`ifdef BSG_CLK_GEN_PEARL_TAG_SENDER_GAP_EN
  assign count_init = accept ? (cnt_w'(hdr_w) + cnt_w'(len_i)) : cnt_w'(gap_p);
`else
  assign count_init = cnt_w'(hdr_w) + cnt_w'(len_i);
`endif

  bsg_clk_gen_pearl_tag_shifter #(
    .width_p (sh_w),
    .cnt_w_p (cnt_w)
  ) shifter (
    .clk        (clk_i),
    .reset      (reset_i),
    .load       (accept),
    .shift      (sending),
    .count_load (count_load),
    .count_dec  (sending | (state == GAP)),
    .load_data  ({payload_masked, hdr}),
    .count_init (count_init),
    .bit_out    (shift_bit),
    .count      (count)
  );

  // The start bit goes straight to tag_data_o on accept; count then holds the bits still to send.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      tag_data_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      last       <= 1'b0;
      len_q      <= '0;
    end else begin
      done_o <= last;
      last   <= send_last;
      unique case (state)
        IDLE: begin
          tag_data_o <= accept;
          busy_o     <= accept;
          if (accept) begin
            state <= HDR;
            len_q <= len_i;
          end
        end
        HDR, PAYLOAD: begin
          tag_data_o <= shift_bit;
          busy_o     <= 1'b1;
          if (send_last)
            state <= gap_en ? GAP : IDLE;
          else if ((state == HDR) && (count == (cnt_w'(len_q) + cnt_w'(1))))
            state <= PAYLOAD;
        end
        GAP: begin
          tag_data_o <= 1'b0;
          busy_o     <= 1'b1;
          if (count == cnt_w'(1))
            state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          tag_data_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_clk_gen_pearl_tag_sender.sv
// Directed bench for bsg_clk_gen_pearl_tag_sender (16 nodes, 4-bit length field):
// expected wire bits are queued per cycle on accept and checked every cycle.
module tb_bsg_clk_gen_pearl_tag_sender;

  localparam int GAP_P = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic        ready_and_o;
  logic [3:0]  node_id_i;
  logic        data_not_reset_i;
  logic [3:0]  len_i;
  logic [14:0] payload_i;
  logic        tag_data_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int   c;
    logic b;
  } exp_t;

  exp_t bit_q[$];
  int   done_q[$];

  bsg_clk_gen_pearl_tag_sender #(
    .tag_els_p      (16),
    .tag_lg_width_p (4),
    .gap_p          (GAP_P)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .v_i              (v_i),
    .ready_and_o      (ready_and_o),
    .node_id_i        (node_id_i),
    .data_not_reset_i (data_not_reset_i),
    .len_i            (len_i),
    .payload_i        (payload_i),
    .tag_data_o       (tag_data_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Per-cycle scoreboard: a queued bit for this cycle means busy with that level, else idle zero.
  always @(negedge clk_i) begin
    logic eb, ebusy, ed;
    eb = 1'b0; ebusy = 1'b0; ed = 1'b0;
    if (mon_en) begin
      if (bit_q.size() > 0 && bit_q[0].c == cyc) begin
        eb    = bit_q[0].b;
        ebusy = 1'b1;
        void'(bit_q.pop_front());
      end
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        ed = 1'b1;
        void'(done_q.pop_front());
      end
      chk("tag_data", {31'd0, tag_data_o}, {31'd0, eb});
      chk("busy",     {31'd0, busy_o},     {31'd0, ebusy});
      chk("done",     {31'd0, done_o},     {31'd0, ed});
    end
  end

  task automatic send(input logic [3:0] node, input logic dnr, input logic [3:0] len,
                      input logic [14:0] pay, input bit hold, output int c);
    bit got;
    int n;
    got = 1'b0;
    c   = -1;
    node_id_i        = node;
    data_not_reset_i = dnr;
    len_i            = len;
    payload_i        = pay;
    v_i              = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk_i);
      got = (ready_and_o === 1'b1);
      @(posedge clk_i);
      #1;
    end
    chk("accept_timeout", {31'd0, got}, 32'd1);
    if (got) begin
      c = cyc;
      n = 0;
      bit_q.push_back(exp_t'{c + n, 1'b1}); n++;
      for (int i = 0; i < 4; i++) begin bit_q.push_back(exp_t'{c + n, node[i]}); n++; end
      bit_q.push_back(exp_t'{c + n, dnr}); n++;
      for (int i = 0; i < 4; i++) begin bit_q.push_back(exp_t'{c + n, len[i]}); n++; end
      for (int i = 0; i < int'(len); i++) begin bit_q.push_back(exp_t'{c + n, pay[i]}); n++; end
      done_q.push_back(c + n);
`ifdef BSG_CLK_GEN_PEARL_TAG_SENDER_GAP_EN
      for (int i = 0; i < GAP_P; i++) bit_q.push_back(exp_t'{c + n + i, 1'b0});
`endif
    end
    if (!hold) v_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_i);
      if (bit_q.size() == 0 && done_q.size() == 0) break;
    end
    chk("drain_bits", bit_q.size(), 0);
    chk("drain_done", done_q.size(), 0);
    @(posedge clk_i);
    #1;
  endtask

  function automatic int pkt_len(input logic [3:0] len);
    return 10 + int'(len);
  endfunction

  initial begin
    int c1, c2, extra;
    extra = 0;
`ifdef BSG_CLK_GEN_PEARL_TAG_SENDER_GAP_EN
    extra = GAP_P;
`endif
    reset_i = 1'b1; v_i = 1'b0; node_id_i = '0; data_not_reset_i = 1'b0;
    len_i = '0; payload_i = '0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    mon_en = 1'b1;
    @(negedge clk_i);
    chk("reset_ready", {31'd0, ready_and_o}, 32'd1);
    @(posedge clk_i); #1;

    // node 3, data, 2-bit payload 2'b10 -> 1,1100,1,0100,01
    send(4'd3, 1'b1, 4'd2, 15'h0002, 1'b0, c1);
    @(negedge clk_i);
    chk("ready_while_busy", {31'd0, ready_and_o}, 32'd0);
    wait_idle();

    // header-only client-reset packet; high payload bits must be ignored
    send(4'd5, 1'b0, 4'd0, 15'h7FFF, 1'b0, c1);
    wait_idle();

    // maximum length, all-ones payload
    send(4'd15, 1'b1, 4'd15, 15'h7FFF, 1'b0, c1);
    wait_idle();

    // bits above len set in payload_i
    send(4'd1, 1'b1, 4'd3, 15'h7FFA, 1'b0, c1);
    wait_idle();

    // back-to-back with v_i held high
    send(4'd9, 1'b1, 4'd3, 15'h0005, 1'b1, c1);
    send(4'd2, 1'b0, 4'd1, 15'h0001, 1'b0, c2);
    chk("b2b_accept_cycle", c2, c1 + pkt_len(4'd3) + extra);
    wait_idle();

    // reset during the fifth bit of a packet
    send(4'd3, 1'b1, 4'd2, 15'h0002, 1'b0, c1);
    repeat (4) @(posedge clk_i);
    #2 reset_i = 1'b1;
    while (bit_q.size() > 0 && bit_q[bit_q.size()-1].c > cyc) void'(bit_q.pop_back());
    done_q.delete();
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    chk("ready_after_reset", {31'd0, ready_and_o}, 32'd1);
    wait_idle();

    // inputs change while the packet is in flight
    send(4'd6, 1'b1, 4'd8, 15'h00A5, 1'b0, c1);
    for (int k = 0; k < 8; k++) begin
      node_id_i        = 4'(k * 5 + 1);
      data_not_reset_i = k[0];
      len_i            = 4'(15 - k);
      payload_i        = 15'(k * 13'h1357);
      @(posedge clk_i); #1;
    end
    wait_idle();

    // idle after everything
    repeat (3) @(posedge clk_i);
    #1;
    chk("final_ready", {31'd0, ready_and_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
